// File: rtl/storage_arbiter.sv
// storage_arbiter: round-robin share of the storage_controller port.
// One transaction in flight, per-transaction timeout, programming-mode hold-off.
module storage_arbiter #(
  parameter int N_REQ          = 3,
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0]        req_we,
  input  logic [N_REQ*XLEN-1:0]   req_addr,
  input  logic [N_REQ*XLEN-1:0]   req_wdata,
  input  logic [N_REQ*XLEN/8-1:0] req_be,
  output logic [N_REQ-1:0]        gnt,
  output logic [N_REQ-1:0]        resp_valid,
  output logic                    resp_err,
  output logic [XLEN-1:0]         resp_rdata,
  input  logic                    set_programming_mode,
  output logic                    busy,
  output logic                    memory_access,
  output logic                    memory_is_writing,
  output logic [XLEN-1:0]         mem_addr,
  output logic [XLEN-1:0]         mem_d_in,
  output logic [XLEN/8-1:0]       mem_be,
  input  logic [XLEN-1:0]         mem_d_out,
  input  logic                    mem_out_valid
);

  localparam int BW = XLEN / 8;
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  state_t          state;
  state_t          state_n;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   ptr_n;
  logic [PW-1:0]   win_idx;
  logic [PW-1:0]   hi_idx;
  logic [PW-1:0]   lo_idx;
  logic            hi_found;
  logic            lo_found;
  logic            win_found;
  logic [N_REQ-1:0] win_oh;
  logic [N_REQ-1:0] owner;
  logic            start;
  logic            tmo;
  logic            done;
  logic [CW-1:0]   cnt;
  logic            sel_we;
  logic [XLEN-1:0] sel_addr;
  logic [XLEN-1:0] sel_wdata;
  logic [BW-1:0]   sel_be;

  // Lowest requester at or above ptr wins; otherwise wrap to lowest overall.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_found = 1'b1;
        lo_idx   = PW'(i);
        if (PW'(i) >= ptr) begin
          hi_found = 1'b1;
          hi_idx   = PW'(i);
        end
      end
    end
    win_found = lo_found;
    win_idx   = hi_found ? hi_idx : lo_idx;
  end

  always_comb begin
    win_oh    = '0;
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_be    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_idx == PW'(i)) begin
        win_oh[i] = 1'b1;
        sel_we    = req_we[i];
        sel_addr  = req_addr[i*XLEN +: XLEN];
        sel_wdata = req_wdata[i*XLEN +: XLEN];
        sel_be    = req_be[i*BW +: BW];
      end
    end
  end

  assign ptr_n = (win_idx == PW'(N_REQ - 1)) ? '0 : win_idx + PW'(1);
  assign start = win_found && !set_programming_mode && (state != BUSY);
  assign tmo   = (cnt == CW'(TIMEOUT_CYCLES - 1));
  assign done  = mem_out_valid || tmo;

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start) state_n = BUSY;
      BUSY:    if (done) state_n = RESP;
      RESP:    state_n = start ? BUSY : IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr               <= '0;
      owner             <= '0;
      cnt               <= '0;
      gnt               <= '0;
      resp_valid        <= '0;
      resp_err          <= 1'b0;
      resp_rdata        <= '0;
      busy              <= 1'b0;
      memory_access     <= 1'b0;
      memory_is_writing <= 1'b0;
      mem_addr          <= '0;
      mem_d_in          <= '0;
      mem_be            <= '0;
    end else begin
      gnt        <= '0;
      resp_valid <= '0;
      if (start) begin
        ptr               <= ptr_n;
        owner             <= win_oh;
        gnt               <= win_oh;
        cnt               <= '0;
        busy              <= 1'b1;
        memory_access     <= 1'b1;
        memory_is_writing <= sel_we;
        mem_addr          <= sel_addr;
        mem_d_in          <= sel_wdata;
        mem_be            <= sel_be;
      end else if (state == BUSY) begin
        if (done) begin
          // out_valid beats a coincident timeout
          resp_valid        <= owner;
          resp_err          <= !mem_out_valid;
          resp_rdata        <= mem_out_valid ? mem_d_out : '0;
          busy              <= 1'b0;
          memory_access     <= 1'b0;
          memory_is_writing <= 1'b0;
          cnt               <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_storage_arbiter.sv
// tb_storage_arbiter: directed steps, response scoreboard,
// behavioural storage_controller with fixed latency.
module tb_storage_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req;
  logic [2:0]  req_we;
  logic [95:0] req_addr;
  logic [95:0] req_wdata;
  logic [11:0] req_be;
  logic [2:0]  gnt;
  logic [2:0]  resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic        spm;
  logic        busy;
  logic        memory_access;
  logic        memory_is_writing;
  logic [31:0] mem_addr;
  logic [31:0] mem_d_in;
  logic [3:0]  mem_be;
  logic [31:0] mem_d_out;
  logic        mem_out_valid;

  typedef struct {
    int          idx;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   glog[$];
  int   tests = 0;
  int   fails = 0;
  logic prev_busy = 1'b0;
  logic ctl_en;
  int   ctl_lat;
  int   ac = 0;

  storage_arbiter #(
    .N_REQ(3),
    .XLEN(32),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .req_we(req_we),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .req_be(req_be),
    .gnt(gnt),
    .resp_valid(resp_valid),
    .resp_err(resp_err),
    .resp_rdata(resp_rdata),
    .set_programming_mode(spm),
    .busy(busy),
    .memory_access(memory_access),
    .memory_is_writing(memory_is_writing),
    .mem_addr(mem_addr),
    .mem_d_in(mem_d_in),
    .mem_be(mem_be),
    .mem_d_out(mem_d_out),
    .mem_out_valid(mem_out_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ctl_fn(logic [31:0] a);
    return a ^ 32'hDEAD_BFEF;
  endfunction

  // controller: out_valid during the (lat+1)-th cycle of memory_access
  always @(posedge clk) begin
    #1;
    if (memory_access) ac = ac + 1;
    else               ac = 0;
    mem_out_valid = ctl_en && memory_access && (ac == ctl_lat + 1);
    mem_d_out     = ctl_fn(mem_addr);
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(int i, logic [31:0] d, logic e);
    exp_t x;
    x.idx  = i;
    x.data = d;
    x.err  = e;
    sb.push_back(x);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(int i, logic we, logic [31:0] a, logic [31:0] wd, logic [3:0] be);
    req[i]             = 1'b1;
    req_we[i]          = we;
    req_addr[i*32+:32] = a;
    req_wdata[i*32+:32] = wd;
    req_be[i*4+:4]     = be;
  endtask

  task automatic wait_resp(string tag, int maxc);
    int n = 0;
    do begin
      step();
      n++;
    end while (resp_valid == 3'b000 && n < maxc);
    chk(tag, 32'(resp_valid != 3'b000), 32'd1);
  endtask

  task automatic wait_gnt(string tag, int maxc, logic [2:0] exp);
    int n = 0;
    do begin
      step();
      n++;
    end while (gnt == 3'b000 && n < maxc);
    chk(tag, 32'(gnt), 32'(exp));
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_gnt"}, 32'(gnt), 32'd0);
    chk({tag, "_rv"}, 32'(resp_valid), 32'd0);
    chk({tag, "_err"}, 32'(resp_err), 32'd0);
    chk({tag, "_rdata"}, resp_rdata, 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_ma"}, 32'(memory_access), 32'd0);
    chk({tag, "_we"}, 32'(memory_is_writing), 32'd0);
    chk({tag, "_addr"}, mem_addr, 32'd0);
    chk({tag, "_din"}, mem_d_in, 32'd0);
    chk({tag, "_be"}, 32'(mem_be), 32'd0);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (gnt != 3'b000) begin
        chk("gnt_onehot", 32'($onehot(gnt)), 32'd1);
        chk("gnt_while_busy", 32'(prev_busy), 32'd0);
        for (int i = 0; i < 3; i++) if (gnt[i]) glog.push_back(i);
      end
      if (resp_valid != 3'b000) begin
        if (sb.size() == 0) begin
          chk("unexpected_resp", 32'(resp_valid), 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("resp_valid", 32'(resp_valid), 32'd1 << e.idx);
          chk("resp_rdata", resp_rdata, e.data);
          chk("resp_err", 32'(resp_err), 32'(e.err));
        end
      end
    end
    prev_busy = busy;
  end

  initial begin
    rst = 1'b0; req = '0; req_we = '0; req_addr = '0;
    req_wdata = '0; req_be = '0; spm = 1'b0;
    ctl_en = 1'b1; ctl_lat = 3;
    mem_out_valid = 1'b0; mem_d_out = '0;
    repeat (2) step();
    chk_all_zero("reset");
    rst = 1'b1;
    step();

    // single read, k=3
    set_req(1, 1'b0, 32'h100, 32'h0, 4'hF);
    push(1, 32'hDEAD_BEEF, 1'b0);
    step();
    chk("rd_gnt", 32'(gnt), 32'h2);
    chk("rd_ma_c1", 32'(memory_access), 32'd1);
    chk("rd_busy", 32'(busy), 32'd1);
    req = '0;
    for (int c = 2; c <= 4; c++) begin
      step();
      chk("rd_ma_hold", 32'(memory_access), 32'd1);
      chk("rd_gnt_pulse", 32'(gnt), 32'd0);
    end
    step();
    chk("rd_rv_c5", 32'(resp_valid), 32'h2);
    chk("rd_data_c5", resp_rdata, 32'hDEAD_BEEF);
    chk("rd_ma_c5", 32'(memory_access), 32'd0);
    step();

    // single write to requester 2
    set_req(2, 1'b1, 32'h40, 32'h1234_5678, 4'b0011);
    push(2, ctl_fn(32'h40), 1'b0);
    step();
    chk("wr_gnt", 32'(gnt), 32'h4);
    req = '0; req_we = '0;
    for (int c = 0; c < 2; c++) begin
      chk("wr_we", 32'(memory_is_writing), 32'd1);
      chk("wr_addr", mem_addr, 32'h40);
      chk("wr_din", mem_d_in, 32'h1234_5678);
      chk("wr_be", 32'(mem_be), 32'h3);
      step();
    end
    wait_resp("wr_resp", 10);
    step();

    // round robin from reset, all requests held
    rst = 1'b0;
    step();
    set_req(0, 1'b0, 32'h10, 32'h0, 4'hF);
    set_req(1, 1'b0, 32'h24, 32'h0, 4'hF);
    set_req(2, 1'b0, 32'h38, 32'h0, 4'hF);
    glog.delete();
    for (int i = 0; i < 6; i++) begin
      push(i % 3, ctl_fn(32'h10 + 32'(i % 3) * 32'h14), 1'b0);
    end
    rst = 1'b1;
    begin
      int n = 0;
      while (glog.size() < 6 && n < 80) begin
        step();
        n++;
      end
    end
    req = '0;
    chk("rr_count", 32'(glog.size()), 32'd6);
    for (int i = 0; i < 6 && i < glog.size(); i++) begin
      chk("rr_order", 32'(glog[i]), 32'(i % 3));
    end
    wait_resp("rr_last", 10);
    step();

    // timeout with TIMEOUT_CYCLES=8
    ctl_en = 1'b0;
    set_req(0, 1'b0, 32'h200, 32'h0, 4'hF);
    push(0, 32'h0, 1'b1);
    step();
    chk("to_gnt", 32'(gnt), 32'h1);
    req = '0;
    repeat (7) step();
    chk("to_c8", 32'(resp_valid), 32'd0);
    step();
    chk("to_rv_c9", 32'(resp_valid), 32'h1);
    chk("to_err_c9", 32'(resp_err), 32'd1);
    chk("to_rdata_c9", resp_rdata, 32'd0);
    ctl_en = 1'b1;
    set_req(1, 1'b0, 32'h300, 32'h0, 4'hF);
    push(1, ctl_fn(32'h300), 1'b0);
    wait_gnt("to_next_gnt", 5, 3'b010);
    req = '0;
    wait_resp("to_next_resp", 10);

    // programming mode hold-off
    spm = 1'b1;
    set_req(0, 1'b0, 32'h400, 32'h0, 4'hF);
    for (int c = 0; c < 20; c++) begin
      step();
      chk("pm_gnt", 32'(gnt), 32'd0);
      chk("pm_ma", 32'(memory_access), 32'd0);
    end
    spm = 1'b0;
    push(0, ctl_fn(32'h400), 1'b0);
    step();
    chk("pm_release_gnt", 32'(gnt), 32'h1);
    req = '0;
    step();
    spm = 1'b1;
    wait_resp("pm_inflight", 10);
    step();
    spm = 1'b0;

    // reset while waiting for out_valid
    ctl_en = 1'b0;
    set_req(2, 1'b0, 32'h500, 32'h0, 4'hF);
    step();
    chk("rb_gnt", 32'(gnt), 32'h4);
    req = '0;
    repeat (2) step();
    rst = 1'b0;
    #1;
    chk_all_zero("rb_async");
    set_req(1, 1'b0, 32'h600, 32'h0, 4'hF);
    set_req(2, 1'b0, 32'h700, 32'h0, 4'hF);
    repeat (3) begin
      step();
      chk("rb_no_resp", 32'(resp_valid), 32'd0);
    end
    ctl_en = 1'b1;
    push(1, ctl_fn(32'h600), 1'b0);
    rst = 1'b1;
    step();
    chk("rb_ptr0_gnt", 32'(gnt), 32'h2);
    req = '0;
    wait_resp("rb_resp", 10);
    step();

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/storage_arbiter.md
Name: storage_arbiter

Overview:
- Shares the single `storage_controller` memory-access port between N requesters: instruction fetch, scalar load/store and vector LSU.
- Round-robin arbitration, one outstanding transaction, per-transaction timeout.
- Holds off all grants while `set_programming_mode` is high.
- Sits between the core/vector memory stages and `storage_controller`, driving its `memory_access`, `memory_is_writing`, `addr`, `d_in` and `mem_be` inputs.

Parameters:
- N_REQ, 3, number of requesters (index 0 = ifetch, 1 = scalar LSU, 2 = vector LSU)
- XLEN, 32, address/data width
- TIMEOUT_CYCLES, 1024, cycles to wait for `out_valid` before aborting

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- req  in  N_REQ  per-requester request, level
- req_we  in  N_REQ  per-requester write enable
- req_addr  in  N_REQ*XLEN  packed addresses, requester i at [i*XLEN +: XLEN]
- req_wdata  in  N_REQ*XLEN  packed write data
- req_be  in  N_REQ*XLEN/8  packed byte enables
- gnt  out  N_REQ  one-hot, one-cycle grant pulse
- resp_valid  out  N_REQ  one-hot, one-cycle completion pulse
- resp_err  out  1  qualifies `resp_valid`: transaction timed out
- resp_rdata  out  XLEN  read data, valid with `resp_valid`
- set_programming_mode  in  1  blocks new grants while high
- busy  out  1  transaction in flight
- memory_access  out  1  to `storage_controller`
- memory_is_writing  out  1  to `storage_controller`
- mem_addr  out  XLEN  to `storage_controller` addr
- mem_d_in  out  XLEN  to `storage_controller` d_in
- mem_be  out  XLEN/8  to `storage_controller` mem_be
- mem_d_out  in  XLEN  from `storage_controller` d_out
- mem_out_valid  in  1  from `storage_controller` out_valid

Behaviour:
- Reset (rst=0, async):
  - state IDLE, rr pointer 0, timeout counter 0.
  - All outputs 0: `gnt`, `resp_valid`, `resp_err`, `resp_rdata`, `busy`, `memory_access`, `memory_is_writing`, `mem_addr`, `mem_d_in`, `mem_be`.
- States: IDLE, BUSY, RESP.
- IDLE:
  - On an edge where `|req` and `!set_programming_mode`: pick the winner by searching `req` from index `ptr` upward, wrapping at N_REQ.
  - Latch the winner's we/addr/wdata/be into the `mem_*` registers.
  - Next cycle: `memory_access`=1, `gnt[winner]`=1 for exactly one cycle, `busy`=1, `ptr`=(winner+1) mod N_REQ.
  - Go to BUSY.
- BUSY:
  - `memory_access` and all `mem_*` outputs held stable.
  - Counter increments each cycle.
  - On `mem_out_valid`=1: capture `mem_d_out` into `resp_rdata`, `resp_err`=0, go to RESP.
  - Else when counter reaches TIMEOUT_CYCLES-1: `resp_rdata`=0, `resp_err`=1, go to RESP.
- RESP (one cycle):
  - `resp_valid[winner]`=1, `memory_access`=0, `busy`=0, counter cleared.
  - Return to IDLE.
  - A new grant can be issued at the earliest on the edge ending RESP, i.e. back-to-back throughput is 1 transaction per (k+2) cycles, where k is the controller latency.
- Latency for a request seen at edge 0 and controller `out_valid` k cycles after access:
  - `gnt`/`memory_access` high at cycle 1.
  - `resp_valid` at cycle k+2.
- Requester handshake:
  - Requester holds `req` and fields stable until it sees `gnt`, then drops `req` or presents its next request.
  - Fields are sampled only at the capture edge.
  - `req` still high while BUSY/RESP is ignored; no double issue.
- `set_programming_mode`:
  - Only gates new grants.
  - An in-flight transaction completes or times out normally.
- Simultaneous `mem_out_valid` and timeout on the same cycle: `out_valid` wins, `resp_err`=0.
- `mem_out_valid` in IDLE or RESP: ignored.
- Reset mid-transaction: immediate return to IDLE with all outputs 0; the in-flight response is dropped and no `resp_valid` is issued.
- `gnt` and `resp_valid` are always one-hot or zero.

Test Plan:
- Single read: `req[1]`, addr 0x100, controller returns 0xDEADBEEF after 3 cycles.
  - Required: `gnt[1]` at cycle 1, `memory_access` high cycles 1–4, `resp_valid[1]` at cycle 5 with `resp_rdata`=0xDEADBEEF, `resp_err`=0.
- Single write: `req[2]`, `we`=1, addr 0x40, wdata 0x12345678, be 4'b0011.
  - Required: `mem_addr`, `mem_d_in` and `mem_be` show these exact values while `memory_is_writing`=1; `resp_valid[2]` after `out_valid`.
- Round-robin: all three `req` held high continuously from reset.
  - Required: grant order 0,1,2,0,1,2; no grant during BUSY.
- Timeout: TIMEOUT_CYCLES=8, `out_valid` never asserted.
  - Required: `resp_valid` pulse with `resp_err`=1 and `resp_rdata`=0 at cycle 9 after grant; next request is then served.
- Programming mode: `set_programming_mode`=1 with `req[0]` high for 20 cycles.
  - Required: no `gnt`, `memory_access`=0.
  - Deassert mode → `gnt[0]` on the next cycle. Mode raised mid-BUSY → that transaction still completes.
- Reset mid-BUSY: `rst`=0 while waiting for `out_valid`.
  - Required: all outputs 0 immediately, no `resp_valid`.
  - After release, rr pointer restarts at 0: with req=3'b110 pending, `gnt[1]`.
